lvdc_timing_gen: RTL

Parametrised LVDC timing generator. It produces the bit-time counter (Johnson-coded G stages), the syllable bit and the phase counter that sequence every other LVDC datapath module. It generalises the fixed 7-stage, 3-phase timing chain: stage count and phase count are configurable. It adds run/halt control with word-boundary draining, illegal-state recovery and optional single-stepping. It sits at the top of the computer's clock tree and drives all downstream timing consumers.

---
 rtl/lvdc_timing_gen_pkg.sv | 45 ++++
 rtl/lvdc_timing_gen_if.sv | 49 ++++
 rtl/lvdc_timing_gen_johnson_counter.sv | 42 ++++
 rtl/lvdc_timing_gen.sv | 128 ++++++++++++
 4 files changed

// File: rtl/lvdc_timing_gen_pkg.sv
// lvdc_timing_pkg: shared types and the Johnson-code decoder for the LVDC
// timing generator.
package lvdc_timing_pkg;

  localparam int GMAX  = 32;  // widest Johnson chain the decoder handles
  localparam int IDX_W = 6;   // binary index width, enough for 2*GMAX codes

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } timing_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } johnson_dec_t;

  // Index k <= gw has the low k bits set; index gw+j has all gw bits set
  // except the low j bits. Any other pattern is reported as invalid.
  function automatic johnson_dec_t johnson_to_bin(input logic [GMAX-1:0] g,
                                                  input int gw);
    johnson_dec_t    res;
    logic [GMAX-1:0] ones;
    logic [GMAX-1:0] mask;
    logic [GMAX-1:0] code;
    res.valid = 1'b0;
    res.idx   = '0;
    ones      = '1;
    code      = '0;
    mask      = ones >> (GMAX - gw);
    for (int k = 0; k < 2 * GMAX; k++) begin
      if (k < 2 * gw) begin
        if (k <= gw) code = ones >> (GMAX - k);
        else         code = mask & ~(ones >> (GMAX - (k - gw)));
        if (g == code) begin
          res.valid = 1'b1;
          res.idx   = IDX_W'(k);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lvdc_timing_gen_if.sv
// lvdc_timing_gen_if: control inputs and timing outputs of the LVDC timing
// generator. The step signal exists only when TIMING_STEP_EN is defined.
//
// Handshake: there is no valid/ready pair. run, halt_req and step are levels
// sampled on every rising clk edge; every output is a register or a decode of
// registers and is valid for the whole cycle.
interface lvdc_timing_gen_if #(
  parameter int G_WIDTH    = 7,
  parameter int NUM_PHASES = 3
);
  import lvdc_timing_pkg::*;

  localparam int NBIT = 2 * G_WIDTH;
  localparam int BT_W = $clog2(NBIT);
  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  logic                  run;
  logic                  halt_req;
`ifdef TIMING_STEP_EN
  logic                  step;
`endif
  logic [G_WIDTH-1:0]    g;
  logic [BT_W-1:0]       bit_time;
  logic                  syl;
  logic [PH_W-1:0]       phase;
  logic [NUM_PHASES-1:0] phase_oh;
  logic                  last_bit;
  logic                  word_end;
  logic                  halted;
  logic                  err;
  timing_state_t         state_dbg;

`ifdef TIMING_STEP_EN
  modport master (output run, halt_req, step,
                  input  g, bit_time, syl, phase, phase_oh, last_bit,
                         word_end, halted, err, state_dbg);
  modport slave  (input  run, halt_req, step,
                  output g, bit_time, syl, phase, phase_oh, last_bit,
                         word_end, halted, err, state_dbg);
`else
  modport master (output run, halt_req,
                  input  g, bit_time, syl, phase, phase_oh, last_bit,
                         word_end, halted, err, state_dbg);
  modport slave  (input  run, halt_req,
                  output g, bit_time, syl, phase, phase_oh, last_bit,
                         word_end, halted, err, state_dbg);
`endif

endinterface

// File: rtl/lvdc_timing_gen_johnson_counter.sv
// johnson_counter: G_WIDTH-stage Johnson ring with synchronous clear and a
// decode of its state into a binary index plus a validity flag.
module johnson_counter
  import lvdc_timing_pkg::*;
#(
  parameter int G_WIDTH = 7
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               tick_i,
  input  logic               clear_i,
  output logic [G_WIDTH-1:0] g_o,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [G_WIDTH-1:0] g_q, g_d;
  johnson_dec_t       dec;

  // Next Johnson state: clear wins over the shift.
  always_comb begin
    g_d = g_q;
    if (clear_i)     g_d = '0;
    else if (tick_i) g_d = {g_q[G_WIDTH-2:0], ~g_q[G_WIDTH-1]};
  end

  // Johnson stage register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) g_q <= '0;
    else          g_q <= g_d;
  end

  // Decode the current state for the consistency check in the parent.
  always_comb begin
    dec     = johnson_to_bin(GMAX'(g_q), G_WIDTH);
    valid_o = dec.valid;
    idx_o   = dec.idx;
  end

  assign g_o = g_q;

endmodule

// File: rtl/lvdc_timing_gen.sv
// lvdc_timing_gen: LVDC bit-time / syllable / phase sequencer with run/halt
// control that always halts on a word boundary and self-recovers from a
// corrupted Johnson state. Defining TIMING_STEP_EN adds single-stepping
// while halted.
module lvdc_timing_gen
  import lvdc_timing_pkg::*;
#(
  parameter int G_WIDTH    = 7,
  parameter int NUM_PHASES = 3
) (
  input logic              clk,
  input logic              rst_n,
  lvdc_timing_gen_if.slave tif
);

  localparam int NBIT = 2 * G_WIDTH;
  localparam int BT_W = $clog2(NBIT);
  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  timing_state_t      state_q, state_d;
  logic [BT_W-1:0]    bit_time_q, bit_time_d;
  logic               syl_q, syl_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic               err_q;
  logic [G_WIDTH-1:0] jc_g;
  logic               jc_valid;
  logic [IDX_W-1:0]   jc_idx;
  logic               last_bit, word_end, recover, tick, tick_eff;

  johnson_counter #(.G_WIDTH(G_WIDTH)) u_jc (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .tick_i  (tick_eff),
    .clear_i (recover),
    .g_o     (jc_g),
    .valid_o (jc_valid),
    .idx_o   (jc_idx)
  );

  // Word-position decodes and the g/bit_time consistency check.
  always_comb begin
    last_bit = (bit_time_q == BT_W'(NBIT - 1));
    word_end = last_bit & syl_q;
    recover  = ~(jc_valid & (jc_idx == IDX_W'(bit_time_q)));
  end

  // Tick qualification: running states follow run; stepping only while a
  // halt is still requested, so a release of halt_req never adds a tick.
  always_comb begin
    tick = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && tif.run;
`ifdef TIMING_STEP_EN
    if ((state_q == ST_HALTED) && tif.step && tif.halt_req) tick = 1'b1;
`endif
    tick_eff = tick & ~recover;
  end

  // Control FSM next state: a halt always runs to the end of a full word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (tif.halt_req) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!tif.halt_req)            state_d = ST_RUN;
        else if (tick_eff && word_end) state_d = ST_HALTED;
      end
      ST_HALTED: if (!tif.halt_req) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Control FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Counter next state: recovery zeroes the word position but keeps phase.
  always_comb begin
    bit_time_d = bit_time_q;
    syl_d      = syl_q;
    phase_d    = phase_q;
    if (recover) begin
      bit_time_d = '0;
      syl_d      = 1'b0;
    end else if (tick_eff) begin
      if (last_bit) begin
        bit_time_d = '0;
        syl_d      = ~syl_q;
      end else begin
        bit_time_d = bit_time_q + BT_W'(1);
      end
      if (word_end)
        phase_d = (phase_q == PH_W'(NUM_PHASES - 1)) ? '0 : phase_q + PH_W'(1);
    end
  end

  // Counter and error-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_time_q <= '0;
      syl_q      <= 1'b0;
      phase_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      bit_time_q <= bit_time_d;
      syl_q      <= syl_d;
      phase_q    <= phase_d;
      err_q      <= recover;
    end
  end

  // Output decodes of the registered state.
  always_comb begin
    for (int i = 0; i < NUM_PHASES; i++)
      tif.phase_oh[i] = (phase_q == PH_W'(i));
  end

  assign tif.g         = jc_g;
  assign tif.bit_time  = bit_time_q;
  assign tif.syl       = syl_q;
  assign tif.phase     = phase_q;
  assign tif.last_bit  = last_bit;
  assign tif.word_end  = word_end;
  assign tif.halted    = (state_q == ST_HALTED);
  assign tif.err       = err_q;
  assign tif.state_dbg = state_q;

endmodule
